// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared definitions for the alarm controller: FSM state encodings,
// clock-field widths and day/hour limits, plus a range check for
// programmed hour:minute values.
package alarm_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    // Wide enough for MAX_SNOOZE(3) * SNOOZE_MIN(59) = 177 minutes.
    localparam int OFFSET_W = 8;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } alarm_state_e;

    function automatic logic hm_valid(input logic [HOUR_W-1:0] hour,
                                      input logic [MIN_W-1:0]  minute);
        return (hour < HOUR_W'(HOURS_PER_DAY)) && (minute < MIN_W'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/alarm_time_add.sv
// alarm_time_add
// Combinational hour:minute + offset-minutes adder with minute and
// hour wrap-around (59 -> 0 carries into the hour, 23 -> 0).
// Ports:
//   hour_in, min_in : base time (expected 0..23 / 0..59)
//   offset_min      : minutes to add
//   hour_out, min_out : wrapped result
//   valid           : base time was in range; when low the result is
//                     meaningless and must not be used for matching
module alarm_time_add
    import alarm_pkg::*;
(
    input  logic [HOUR_W-1:0]   hour_in,
    input  logic [MIN_W-1:0]    min_in,
    input  logic [OFFSET_W-1:0] offset_min,
    output logic [HOUR_W-1:0]   hour_out,
    output logic [MIN_W-1:0]    min_out,
    output logic                valid
);

    localparam int SUM_W = 9;

    logic [SUM_W-1:0] min_sum;
    logic [SUM_W-1:0] hour_sum;

    always_comb begin
        min_sum  = SUM_W'(min_in) + SUM_W'(offset_min);
        hour_sum = SUM_W'(hour_in) + (min_sum / SUM_W'(MIN_PER_HOUR));
        min_out  = MIN_W'(min_sum % SUM_W'(MIN_PER_HOUR));
        hour_out = HOUR_W'(hour_sum % SUM_W'(HOURS_PER_DAY));
        // A wrapped result could land back in range, so out-of-range
        // inputs are flagged rather than silently folded.
        valid    = hm_valid(hour_in, min_in);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
// Alarm-clock sequencer: compares the current time against the
// programmed alarm (pushed out by SNOOZE_MIN per snooze taken), rings,
// and handles stop / snooze / ring timeout.
// Ports:
//   clock, reset          : divided clock, async active-high reset
//   alarm_enable          : 1 = alarm armed
//   alarm_hour, alarm_min : programmed alarm time
//   time_hour/min/sec     : current time
//   stop_btn, snooze_btn  : single-cycle debounced pulses
//   ring                  : 1 while sounding
//   state                 : FSM state code
//   snooze_cnt            : snoozes taken in the current event
//
// state       | meaning
// ------------+---------------------------------------------
// DISARMED(0) | alarm_enable low, nothing evaluated
// ARMED(1)    | waiting for a match on the current target
// RINGING(2)  | sounding; timeout counter running
// SNOOZE(3)   | silenced; waiting for the pushed-out target
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT = 180,
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alarm_enable,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic [HOUR_W-1:0] time_hour,
    input  logic [MIN_W-1:0]  time_min,
    input  logic [SEC_W-1:0]  time_sec,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              ring,
    output logic [1:0]        state,
    output logic [1:0]        snooze_cnt
);

    localparam int              TO_W         = $clog2(RING_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST      = TO_W'(RING_TIMEOUT - 1);
    localparam logic [1:0]      SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    alarm_state_e      state_q, state_d;
    logic [1:0]        snooze_cnt_q, snooze_cnt_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    // Previous-cycle match; resets high so 00:00:00 at reset release
    // cannot look like a fresh match.
    logic              match_dly_q;

    logic [OFFSET_W-1:0] offset_min;
    logic [HOUR_W-1:0]   target_hour;
    logic [MIN_W-1:0]    target_min;
    logic                target_valid;
    logic                match;
    logic                trigger;

    assign offset_min = OFFSET_W'(snooze_cnt_q) * OFFSET_W'(SNOOZE_MIN);

    alarm_time_add u_time_add (
        .hour_in   (alarm_hour),
        .min_in    (alarm_min),
        .offset_min(offset_min),
        .hour_out  (target_hour),
        .min_out   (target_min),
        .valid     (target_valid)
    );

    // Target is not latched: edits to the alarm time apply immediately.
    assign match   = target_valid && (time_hour == target_hour) &&
                     (time_min == target_min) && (time_sec == '0);
    assign trigger = match && !match_dly_q;

    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        timeout_d    = timeout_q;
        if (!alarm_enable) begin
            state_d      = ST_DISARMED;
            snooze_cnt_d = '0;
            timeout_d    = '0;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trigger) begin
                        state_d   = ST_RINGING;
                        timeout_d = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop_btn) begin
                        state_d      = ST_ARMED;
                        snooze_cnt_d = '0;
                    end else if (snooze_btn) begin
                        // Snooze beyond the limit is ignored outright.
                        if (snooze_cnt_q < SNOOZE_LIMIT) begin
                            state_d      = ST_SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                        end
                    end else if (timeout_q == TO_LAST) begin
                        state_d      = ST_ARMED;
                        snooze_cnt_d = '0;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
                ST_SNOOZE: begin
                    // Stop wins over a coincident trigger; the edge
                    // detector then swallows that match.
                    if (stop_btn) begin
                        state_d      = ST_ARMED;
                        snooze_cnt_d = '0;
                    end else if (trigger) begin
                        state_d   = ST_RINGING;
                        timeout_d = '0;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_DISARMED;
            snooze_cnt_q <= '0;
            timeout_q    <= '0;
            match_dly_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            snooze_cnt_q <= snooze_cnt_d;
            timeout_q    <= timeout_d;
            match_dly_q  <= match;
        end
    end

    // Decoded straight from the state register so reset silences the
    // alarm without waiting for an edge.
    assign ring       = (state_q == ST_RINGING);
    assign state      = state_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule
